control_mc: RTL and testbench

Multi-cycle successor to the single-cycle RV32I control unit. Sequences FETCH/DECODE/EXEC/MEM/WB over a latched instruction register and generates every datapath select, ALU op, register-file and memory strobe. Covers full RV32I integer (OP, OP-IMM, LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE) with req/ack handshakes on instruction and data memory, a memory-timeout watchdog, and a sticky halt on illegal instructions.

---
 rtl/control_mc_pkg.sv | 71 +++++++
 rtl/control_mc_if.sv | 21 ++
 rtl/control_mc_imm_gen.sv | 33 +++
 rtl/control_mc.sv | 222 ++++++++++++++++++++++
 tb/tb_control_mc.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/control_mc_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control unit.
// Select and ALU-op codes are part of the datapath contract, so keep them stable.
package ctrl_pkg;

  typedef enum logic [2:0] {
    RESET  = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    HALT   = 3'd6
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_OP_ADD    = 4'd0;
  localparam logic [3:0] ALU_OP_SUB    = 4'd1;
  localparam logic [3:0] ALU_OP_SLL    = 4'd2;
  localparam logic [3:0] ALU_OP_SLT    = 4'd3;
  localparam logic [3:0] ALU_OP_SLTU   = 4'd4;
  localparam logic [3:0] ALU_OP_XOR    = 4'd5;
  localparam logic [3:0] ALU_OP_SRL    = 4'd6;
  localparam logic [3:0] ALU_OP_SRA    = 4'd7;
  localparam logic [3:0] ALU_OP_OR     = 4'd8;
  localparam logic [3:0] ALU_OP_AND    = 4'd9;
  localparam logic [3:0] ALU_OP_PASS_B = 4'd10;
  // Branch compares (BLT/BLTU reuse SLT/SLTU); the result adder still forms PC+imm.
  localparam logic [3:0] ALU_OP_EQ     = 4'd11;
  localparam logic [3:0] ALU_OP_NE     = 4'd12;
  localparam logic [3:0] ALU_OP_GE     = 4'd13;
  localparam logic [3:0] ALU_OP_GEU    = 4'd14;

  localparam logic ALU_A_SEL_RS1 = 1'b0;
  localparam logic ALU_A_SEL_PC  = 1'b1;
  localparam logic ALU_B_SEL_RS2 = 1'b0;
  localparam logic ALU_B_SEL_IMM = 1'b1;

  localparam logic [1:0] REG_SEL_ALU = 2'd0;
  localparam logic [1:0] REG_SEL_MEM = 2'd1;
  localparam logic [1:0] REG_SEL_PC4 = 2'd2;

  localparam logic [1:0] PC_NEXT_SEL_SAME   = 2'd0;
  localparam logic [1:0] PC_NEXT_SEL_INC    = 2'd1;
  localparam logic [1:0] PC_NEXT_SEL_TARGET = 2'd2;

  function automatic logic [3:0] arith_op(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'b000:  arith_op = alt ? ALU_OP_SUB : ALU_OP_ADD;
      3'b001:  arith_op = ALU_OP_SLL;
      3'b010:  arith_op = ALU_OP_SLT;
      3'b011:  arith_op = ALU_OP_SLTU;
      3'b100:  arith_op = ALU_OP_XOR;
      3'b101:  arith_op = alt ? ALU_OP_SRA : ALU_OP_SRL;
      3'b110:  arith_op = ALU_OP_OR;
      default: arith_op = ALU_OP_AND;
    endcase
  endfunction

endpackage

// File: rtl/control_mc_if.sv
// Instruction- and data-memory handshake bundle seen by the control unit.
interface control_mc_if;
  logic        fetch_req_o;
  logic        instr_valid_i;
  logic [31:0] instr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [1:0]  mem_size_o;
  logic        mem_unsigned_o;
  logic        mem_ack_i;

  modport master (
    output fetch_req_o, mem_req_o, mem_we_o, mem_size_o, mem_unsigned_o,
    input  instr_valid_i, instr_i, mem_ack_i
  );

  modport slave (
    input  fetch_req_o, mem_req_o, mem_we_o, mem_size_o, mem_unsigned_o,
    output instr_valid_i, instr_i, mem_ack_i
  );
endinterface

// File: rtl/control_mc_imm_gen.sv
// Immediate extraction for the I/S/B/U/J formats, sign-extended from ir[31].
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;

  always_comb begin
    imm32 = '0;
    case (ir[6:0])
      OPC_OP_IMM, OPC_JALR, OPC_LOAD:
        imm32 = {{20{ir[31]}}, ir[31:20]};
      OPC_STORE:
        imm32 = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      OPC_BRANCH:
        imm32 = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        imm32 = {ir[31:12], 12'b0};
      OPC_JAL:
        imm32 = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
  end

  assign imm = XLEN'(imm32);

endmodule

// File: rtl/control_mc.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXEC/MEM/WB over a latched IR,
// with req/ack memory handshakes, a wait watchdog and sticky halt conditions.
module control_mc
  import ctrl_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          RV32E    = 1'b0,
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  control_mc_if.master    bus,
  input  logic            alu_cond_i,
  output logic            wr_en_o,
  output logic [4:0]      rd_idx_o,
  output logic [4:0]      rs1_idx_o,
  output logic [4:0]      rs2_idx_o,
  output logic [XLEN-1:0] imm_data_o,
  output logic [3:0]      alu_op_o,
  output logic            alu_a_sel_o,
  output logic            alu_b_sel_o,
  output logic [1:0]      reg_sel_o,
  output logic            pc_we_o,
  output logic [1:0]      pc_next_sel_o,
  output logic            illegal_o,
  output logic            bus_err_o,
  output logic [2:0]      state_o
);

  localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

  state_e      state_q, state_d;
  logic [31:0] ir_q;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, bus_err_q;

  logic [6:0] opc, funct7;
  logic [2:0] funct3;
  logic       is_branch, is_load, is_store, is_jump;
  logic       legal, uses_rd, uses_rs1, uses_rs2, rv32e_bad, illegal_dec;
  logic       acked, waiting, timeout;

  assign opc       = ir_q[6:0];
  assign funct3    = ir_q[14:12];
  assign funct7    = ir_q[31:25];
  assign is_branch = (opc == OPC_BRANCH);
  assign is_load   = (opc == OPC_LOAD);
  assign is_store  = (opc == OPC_STORE);
  assign is_jump   = (opc == OPC_JAL) || (opc == OPC_JALR);

  assign rd_idx_o  = ir_q[11:7];
  assign rs1_idx_o = ir_q[19:15];
  assign rs2_idx_o = ir_q[24:20];

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .ir  (ir_q),
    .imm (imm_data_o)
  );

  always_comb begin
    legal    = 1'b0;
    uses_rd  = 1'b1;
    uses_rs1 = 1'b1;
    uses_rs2 = 1'b0;
    case (opc)
      OPC_OP: begin
        uses_rs2 = 1'b1;
        legal    = (funct7 == F7_BASE) ||
                   ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
      end
      OPC_OP_IMM: begin
        case (funct3)
          3'b001:  legal = (funct7 == F7_BASE);
          3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          default: legal = 1'b1;
        endcase
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        uses_rs1 = 1'b0;
        legal    = 1'b1;
      end
      OPC_JALR: legal = (funct3 == 3'b000);
      OPC_BRANCH: begin
        uses_rd  = 1'b0;
        uses_rs2 = 1'b1;
        legal    = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      OPC_LOAD: legal = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
      OPC_STORE: begin
        uses_rd  = 1'b0;
        uses_rs2 = 1'b1;
        legal    = (funct3 <= 3'b010);
      end
      default: legal = 1'b0;
    endcase
  end

  // Only fields the format actually uses as register indices are range-checked.
  assign rv32e_bad   = RV32E && ((uses_rd && ir_q[11]) || (uses_rs1 && ir_q[19]) ||
                                 (uses_rs2 && ir_q[24]));
  assign illegal_dec = !legal || rv32e_bad;

  always_comb begin
    alu_op_o    = ALU_OP_ADD;
    alu_a_sel_o = ALU_A_SEL_RS1;
    alu_b_sel_o = ALU_B_SEL_IMM;
    reg_sel_o   = REG_SEL_ALU;
    case (opc)
      OPC_OP: begin
        alu_b_sel_o = ALU_B_SEL_RS2;
        alu_op_o    = arith_op(funct3, funct7[5]);
      end
      OPC_OP_IMM: alu_op_o = arith_op(funct3, (funct3 == 3'b101) && funct7[5]);
      OPC_LUI:    alu_op_o = ALU_OP_PASS_B;
      OPC_AUIPC:  alu_a_sel_o = ALU_A_SEL_PC;
      OPC_JAL: begin
        alu_a_sel_o = ALU_A_SEL_PC;
        reg_sel_o   = REG_SEL_PC4;
      end
      OPC_JALR:   reg_sel_o = REG_SEL_PC4;
      OPC_BRANCH: begin
        alu_a_sel_o = ALU_A_SEL_PC;
        case (funct3)
          3'b001:  alu_op_o = ALU_OP_NE;
          3'b100:  alu_op_o = ALU_OP_SLT;
          3'b101:  alu_op_o = ALU_OP_GE;
          3'b110:  alu_op_o = ALU_OP_SLTU;
          3'b111:  alu_op_o = ALU_OP_GEU;
          default: alu_op_o = ALU_OP_EQ;
        endcase
      end
      OPC_LOAD:   reg_sel_o = REG_SEL_MEM;
      default:    ;
    endcase
  end

  // Counter is zero in every cycle that is not a waiting handshake cycle, which
  // also clears it on FETCH/MEM entry; an ack on the last allowed cycle wins.
  assign acked   = ((state_q == FETCH) && bus.instr_valid_i) ||
                   ((state_q == MEM) && bus.mem_ack_i);
  assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !acked;
  assign timeout = waiting && (wait_q >= WAIT_LAST);
  assign wait_d  = (waiting && !timeout) ? ((wait_q == '1) ? wait_q : wait_q + 8'd1) : '0;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RESET;
      ir_q      <= '0;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if ((state_q == FETCH) && bus.instr_valid_i) ir_q <= bus.instr_i;
      if ((state_q == DECODE) && illegal_dec) illegal_q <= 1'b1;
      if (timeout) bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:  state_d = FETCH;
      FETCH: begin
        if (bus.instr_valid_i) state_d = DECODE;
        else if (timeout)      state_d = HALT;
      end
      DECODE: state_d = illegal_dec ? HALT : EXEC;
      EXEC: begin
        if (is_branch)                state_d = FETCH;
        else if (is_load || is_store) state_d = MEM;
        else                          state_d = WB;
      end
      MEM: begin
        if (bus.mem_ack_i) state_d = is_load ? WB : FETCH;
        else if (timeout)  state_d = HALT;
      end
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
  end

  always_comb begin
    bus.fetch_req_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    wr_en_o         = 1'b0;
    pc_we_o         = 1'b0;
    pc_next_sel_o   = PC_NEXT_SEL_SAME;
    case (state_q)
      FETCH: bus.fetch_req_o = 1'b1;
      EXEC: begin
        if (is_branch) begin
          pc_we_o       = 1'b1;
          pc_next_sel_o = alu_cond_i ? PC_NEXT_SEL_TARGET : PC_NEXT_SEL_INC;
        end
      end
      MEM: begin
        bus.mem_req_o = 1'b1;
        bus.mem_we_o  = is_store;
        if (bus.mem_ack_i && is_store) begin
          pc_we_o       = 1'b1;
          pc_next_sel_o = PC_NEXT_SEL_INC;
        end
      end
      WB: begin
        wr_en_o       = (rd_idx_o != 5'd0);
        pc_we_o       = 1'b1;
        pc_next_sel_o = is_jump ? PC_NEXT_SEL_TARGET : PC_NEXT_SEL_INC;
      end
      default: ;
    endcase
  end

  assign bus.mem_size_o     = funct3[1:0];
  assign bus.mem_unsigned_o = is_load && funct3[2];
  assign illegal_o          = illegal_q;
  assign bus_err_o          = bus_err_q;
  assign state_o            = state_q;

endmodule

// File: tb/tb_control_mc.sv
// Directed bench for control_mc: instruction sequencing, handshake watchdog,
// illegal-instruction halt (incl. RV32E) and reset mid-access.
module tb_control_mc;
  import ctrl_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic alu_cond = 1'b0;
  always #5 clk = ~clk;

  control_mc_if bus();
  control_mc_if bus_e();

  assign bus_e.instr_valid_i = bus.instr_valid_i;
  assign bus_e.instr_i       = bus.instr_i;
  assign bus_e.mem_ack_i     = bus.mem_ack_i;

  logic        wr_en, pc_we, a_sel, b_sel, illegal, bus_err;
  logic [4:0]  rd_idx, rs1_idx, rs2_idx;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [1:0]  reg_sel, pc_next_sel;
  logic [2:0]  state;

  logic        e_wr_en, e_pc_we, e_a_sel, e_b_sel, e_illegal, e_bus_err;
  logic [4:0]  e_rd_idx, e_rs1_idx, e_rs2_idx;
  logic [31:0] e_imm;
  logic [3:0]  e_alu_op;
  logic [1:0]  e_reg_sel, e_pc_next_sel;
  logic [2:0]  e_state;

  control_mc #(.XLEN(32), .RV32E(1'b0), .WAIT_MAX(15)) dut (
    .clk_i(clk), .rstn_i(rstn), .bus(bus), .alu_cond_i(alu_cond),
    .wr_en_o(wr_en), .rd_idx_o(rd_idx), .rs1_idx_o(rs1_idx), .rs2_idx_o(rs2_idx),
    .imm_data_o(imm), .alu_op_o(alu_op), .alu_a_sel_o(a_sel), .alu_b_sel_o(b_sel),
    .reg_sel_o(reg_sel), .pc_we_o(pc_we), .pc_next_sel_o(pc_next_sel),
    .illegal_o(illegal), .bus_err_o(bus_err), .state_o(state)
  );

  control_mc #(.XLEN(32), .RV32E(1'b1), .WAIT_MAX(15)) dut_e (
    .clk_i(clk), .rstn_i(rstn), .bus(bus_e), .alu_cond_i(alu_cond),
    .wr_en_o(e_wr_en), .rd_idx_o(e_rd_idx), .rs1_idx_o(e_rs1_idx), .rs2_idx_o(e_rs2_idx),
    .imm_data_o(e_imm), .alu_op_o(e_alu_op), .alu_a_sel_o(e_a_sel), .alu_b_sel_o(e_b_sel),
    .reg_sel_o(e_reg_sel), .pc_we_o(e_pc_we), .pc_next_sel_o(e_pc_next_sel),
    .illegal_o(e_illegal), .bus_err_o(e_bus_err), .state_o(e_state)
  );

  int n_pass = 0;
  int n_total = 0;
  int wr_cnt = 0;

  always @(negedge clk) if (wr_en) wr_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench on a negedge with rstn high and the DUT still in RESET.
  task automatic reset_dut();
    rstn = 1'b0;
    bus.instr_valid_i = 1'b0;
    bus.instr_i = '0;
    bus.mem_ack_i = 1'b0;
    alu_cond = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  initial begin
    int n;
    int wr0;
    reset_dut();
    check("rst_state", 32'(state), 32'(RESET));
    check("rst_fetch_req", 32'(bus.fetch_req_o), 0);
    check("rst_mem_req", 32'(bus.mem_req_o), 0);
    check("rst_pc_we", 32'(pc_we), 0);
    check("rst_pc_sel", 32'(pc_next_sel), 32'(PC_NEXT_SEL_SAME));
    check("rst_flags", {30'd0, illegal, bus_err}, 0);

    // ADDI x1,x0,5
    bus.instr_i = 32'h00500093;
    bus.instr_valid_i = 1'b1;
    step();
    check("addi_fetch_state", 32'(state), 32'(FETCH));
    check("addi_fetch_req", 32'(bus.fetch_req_o), 1);
    step();
    bus.instr_valid_i = 1'b0;
    check("addi_decode_state", 32'(state), 32'(DECODE));
    check("addi_imm", imm, 32'd5);
    step();
    check("addi_exec_state", 32'(state), 32'(EXEC));
    check("addi_exec_wr_en", 32'(wr_en), 0);
    step();
    check("addi_wb_state", 32'(state), 32'(WB));
    check("addi_wb_wr_en", 32'(wr_en), 1);
    check("addi_wb_rd", 32'(rd_idx), 1);
    check("addi_wb_b_sel", 32'(b_sel), 32'(ALU_B_SEL_IMM));
    check("addi_wb_alu_op", 32'(alu_op), 32'(ALU_OP_ADD));
    check("addi_wb_pc_we", 32'(pc_we), 1);
    check("addi_wb_pc_sel", 32'(pc_next_sel), 32'(PC_NEXT_SEL_INC));
    check("addi_rv32e_wb", 32'(e_state), 32'(WB));
    step();
    check("addi_back_fetch", 32'(state), 32'(FETCH));

    // BEQ x0,x0,-8 taken then not taken
    wr0 = wr_cnt;
    bus.instr_i = 32'hFE000CE3;
    bus.instr_valid_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    check("beq_imm", imm, 32'hFFFFFFF8);
    alu_cond = 1'b1;
    step();
    check("beq_t_state", 32'(state), 32'(EXEC));
    check("beq_t_pc_we", 32'(pc_we), 1);
    check("beq_t_pc_sel", 32'(pc_next_sel), 32'(PC_NEXT_SEL_TARGET));
    check("beq_a_sel", 32'(a_sel), 32'(ALU_A_SEL_PC));
    step();
    check("beq_t_next", 32'(state), 32'(FETCH));
    bus.instr_valid_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    alu_cond = 1'b0;
    step();
    check("beq_nt_pc_we", 32'(pc_we), 1);
    check("beq_nt_pc_sel", 32'(pc_next_sel), 32'(PC_NEXT_SEL_INC));
    step();
    check("beq_nt_next", 32'(state), 32'(FETCH));
    check("beq_no_wr", 32'(wr_cnt - wr0), 0);

    // LW x5,12(x2) with ack after 3 wait cycles
    bus.instr_i = 32'h00C12283;
    bus.instr_valid_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    step();
    step();
    check("lw_mem_state", 32'(state), 32'(MEM));
    check("lw_mem_size", 32'(bus.mem_size_o), 2);
    check("lw_mem_we", 32'(bus.mem_we_o), 0);
    n = 0;
    for (int i = 1; i <= 4; i++) begin
      if (bus.mem_req_o) n++;
      bus.mem_ack_i = (i == 4);
      step();
    end
    bus.mem_ack_i = 1'b0;
    check("lw_req_cycles", 32'(n), 4);
    check("lw_wb_state", 32'(state), 32'(WB));
    check("lw_wb_reg_sel", 32'(reg_sel), 32'(REG_SEL_MEM));
    check("lw_wb_rd", 32'(rd_idx), 5);
    check("lw_wb_wr_en", 32'(wr_en), 1);
    check("lw_wb_mem_req", 32'(bus.mem_req_o), 0);
    step();

    // Slow fetch (10 waits) then SW with ack withheld -> timeout after 15 MEM cycles
    repeat (10) step();
    check("slow_fetch_state", 32'(state), 32'(FETCH));
    check("slow_fetch_no_err", 32'(bus_err), 0);
    bus.instr_i = 32'h00112023;
    bus.instr_valid_i = 1'b1;
    step();
    bus.instr_valid_i = 1'b0;
    step();
    step();
    check("sw_mem_we", 32'(bus.mem_we_o), 1);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (state != 3'(MEM)) break;
      n++;
      step();
    end
    check("sw_to_cycles", 32'(n), 15);
    check("sw_to_bus_err", 32'(bus_err), 1);
    check("sw_to_state", 32'(state), 32'(HALT));
    check("sw_to_mem_req", 32'(bus.mem_req_o), 0);
    repeat (3) step();
    check("sw_halt_stays", 32'(state), 32'(HALT));
    check("sw_halt_no_fetch", 32'(bus.fetch_req_o), 0);

    // SW with ack on the 15th MEM cycle -> completes, no error
    reset_dut();
    bus.instr_i = 32'h00112023;
    bus.instr_valid_i = 1'b1;
    step();
    step();
    bus.instr_valid_i = 1'b0;
    step();
    step();
    for (int i = 1; i <= 15; i++) begin
      if (i == 15) begin
        bus.mem_ack_i = 1'b1;
        #1;
        check("sw_ack15_state", 32'(state), 32'(MEM));
        check("sw_ack15_pc_we", 32'(pc_we), 1);
        check("sw_ack15_pc_sel", 32'(pc_next_sel), 32'(PC_NEXT_SEL_INC));
      end
      step();
    end
    bus.mem_ack_i = 1'b0;
    check("sw_ack15_next", 32'(state), 32'(FETCH));
    check("sw_ack15_no_err", 32'(bus_err), 0);

    // Fetch never answered -> timeout from FETCH
    reset_dut();
    step();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (state != 3'(FETCH)) break;
      n++;
      step();
    end
    check("fetch_to_cycles", 32'(n), 15);
    check("fetch_to_bus_err", 32'(bus_err), 1);
    check("fetch_to_state", 32'(state), 32'(HALT));

    // Illegal opcode 0x7F -> sticky halt, cleared only by reset
    reset_dut();
    bus.instr_i = 32'h0000007F;
    bus.instr_valid_i = 1'b1;
    step();
    step();
    bus.instr_valid_i = 1'b0;
    check("ill_decode_state", 32'(state), 32'(DECODE));
    step();
    check("ill_state", 32'(state), 32'(HALT));
    check("ill_flag", 32'(illegal), 1);
    check("ill_no_bus_err", 32'(bus_err), 0);
    bus.instr_valid_i = 1'b1;
    n = 0;
    repeat (5) begin
      step();
      if (bus.fetch_req_o) n++;
    end
    bus.instr_valid_i = 1'b0;
    check("ill_no_fetch", 32'(n), 0);
    rstn = 1'b0;
    #1;
    check("ill_rst_flag", 32'(illegal), 0);
    check("ill_rst_state", 32'(state), 32'(RESET));
    step();
    rstn = 1'b1;
    step();
    check("ill_refetch", 32'(bus.fetch_req_o), 1);

    // ADD x20,x1,x2: legal on RV32I, illegal on RV32E
    reset_dut();
    bus.instr_i = 32'h00208A33;
    bus.instr_valid_i = 1'b1;
    step();
    step();
    bus.instr_valid_i = 1'b0;
    check("add20_rd", 32'(rd_idx), 20);
    step();
    check("add20_i_state", 32'(state), 32'(EXEC));
    check("add20_i_legal", 32'(illegal), 0);
    check("add20_e_state", 32'(e_state), 32'(HALT));
    check("add20_e_illegal", 32'(e_illegal), 1);

    // Reset asserted during a pending load
    reset_dut();
    bus.instr_i = 32'h00C12283;
    bus.instr_valid_i = 1'b1;
    step();
    step();
    bus.instr_valid_i = 1'b0;
    step();
    step();
    step();
    check("mid_mem_state", 32'(state), 32'(MEM));
    wr0 = wr_cnt;
    rstn = 1'b0;
    #1;
    check("mid_rst_state", 32'(state), 32'(RESET));
    check("mid_rst_mem_req", 32'(bus.mem_req_o), 0);
    bus.mem_ack_i = 1'b1;
    step();
    step();
    bus.mem_ack_i = 1'b0;
    rstn = 1'b1;
    step();
    check("mid_rst_refetch", 32'(state), 32'(FETCH));
    step();
    check("mid_rst_no_wr", 32'(wr_cnt - wr0), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
